// File: rtl/sysarray_result_writer.sv
// sysarray_result_writer
//   Write-back stage of the 3x3 systolic matmul datapath. Samples the array's five
//   result taps at fixed offsets after the first skewed operand edge and de-skews them
//   into a row-major 3x3 result D. D is then written as nine consecutive words into
//   the block RAM port.
//
// Ports
//   clock     : sole clock, all logic on posedge
//   reset     : synchronous, active-high
//   start     : high on the edge that registers the first skewed operands
//   c53..c45  : array result taps (N+1 bits each)
//   mem_ena   : RAM enable, high only while writing
//   mem_wea   : RAM write enable
//   mem_addr  : RAM address (5 bits)
//   mem_dina  : RAM write data
//   busy      : high in every state except idle
//   done      : single-cycle pulse after the ninth write
module sysarray_result_writer #(
  parameter int unsigned N          = 15,
  parameter int unsigned CAP_OFFSET = 5,
  parameter int unsigned BASE_ADDR  = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [N:0] c53,
  input  logic [N:0] c54,
  input  logic [N:0] c55,
  input  logic [N:0] c35,
  input  logic [N:0] c45,
  output logic       mem_ena,
  output logic       mem_wea,
  output logic [4:0] mem_addr,
  output logic [N:0] mem_dina,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW     = $clog2(CAP_OFFSET + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CAP_OFFSET - 1);
  localparam logic [4:0]      BaseAddr = 5'(BASE_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCapture,
    StWrite,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      cap_q;
  logic [3:0]      wr_idx_q;
  logic [N:0]      d_q [9];

  logic [3:0] wr_idx_next;
  assign wr_idx_next = wr_idx_q + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cap_q    <= '0;
      wr_idx_q <= '0;
      mem_ena  <= 1'b0;
      mem_wea  <= 1'b0;
      mem_addr <= '0;
      mem_dina <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy  <= 1'b1;
            cnt_q <= CntW'(1);
            cap_q <= '0;
            // With a one-cycle offset the first capture is the very next edge.
            if (CAP_OFFSET == 1) begin
              state_q <= StCapture;
            end else begin
              state_q <= StWait;
            end
          end
        end

        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StCapture;
          end
        end

        StCapture: begin
          cap_q <= cap_q + 2'd1;
          // Taps emerge skewed: the bottom-right tap produces three results over three
          // edges, the corner taps fewer, so each edge fills a different subset of D.
          case (cap_q)
            2'd0: begin
              d_q[0] <= c55;
              d_q[1] <= c45;
              d_q[2] <= c35;
              d_q[3] <= c54;
              d_q[6] <= c53;
            end
            2'd1: begin
              d_q[4] <= c55;
              d_q[5] <= c45;
              d_q[7] <= c54;
            end
            default: begin
              d_q[8]   <= c55;
              state_q  <= StWrite;
              wr_idx_q <= '0;
              mem_ena  <= 1'b1;
              mem_wea  <= 1'b1;
              mem_addr <= BaseAddr;
              mem_dina <= d_q[0];
            end
          endcase
        end

        StWrite: begin
          if (wr_idx_q == 4'd8) begin
            state_q <= StDone;
            mem_ena <= 1'b0;
            mem_wea <= 1'b0;
            done    <= 1'b1;
          end else begin
            wr_idx_q <= wr_idx_next;
            mem_addr <= BaseAddr + {1'b0, wr_idx_next};
            mem_dina <= d_q[wr_idx_next];
          end
        end

        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysarray_result_writer.sv
module tb_sysarray_result_writer;

  localparam int CA = 5;
  localparam int BA = 18;
  localparam int CB = 1;
  localparam int BB = 23;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] c53 = '0, c54 = '0, c55 = '0, c35 = '0, c45 = '0;

  logic        ena_a, wea_a, busy_a, done_a;
  logic [4:0]  addr_a;
  logic [15:0] dina_a;
  logic        ena_b, wea_b, busy_b, done_b;
  logic [4:0]  addr_b;
  logic [15:0] dina_b;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  bit tap_const = 1'b0;

  // Bench-side RAM models and event records.
  logic [15:0] ram_a [32];
  logic [15:0] ram_b [32];
  int wr_cnt_a, done_cnt_a, first_wr_a, first_done_a, last_done_a, min_addr_a;
  int wr_cnt_b, done_cnt_b, first_wr_b, first_done_b, last_done_b, min_addr_b;

  sysarray_result_writer #(.N(15), .CAP_OFFSET(CA), .BASE_ADDR(BA)) u_dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .c53(c53), .c54(c54), .c55(c55), .c35(c35), .c45(c45),
    .mem_ena(ena_a), .mem_wea(wea_a), .mem_addr(addr_a), .mem_dina(dina_a),
    .busy(busy_a), .done(done_a)
  );

  sysarray_result_writer #(.N(15), .CAP_OFFSET(CB), .BASE_ADDR(BB)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .c53(c53), .c54(c54), .c55(c55), .c35(c35), .c45(c45),
    .mem_ena(ena_b), .mem_wea(wea_b), .mem_addr(addr_b), .mem_dina(dina_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clock = ~clock;

  // Tap tag: value sampled on edge e from tap id (c53=3 c54=4 c55=5 c35=6 c45=7).
  function automatic logic [15:0] tag(input int e, input int id);
    logic [31:0] ev;
    logic [31:0] iv;
    ev = e;
    iv = id;
    return {ev[7:0], 4'h0, iv[3:0]};
  endfunction

  // Expected D[k] given start edge t0 and capture offset c.
  function automatic logic [15:0] exp_word(input int t0, input int c, input int k);
    case (k)
      0:       return tag(t0 + c, 5);
      1:       return tag(t0 + c, 7);
      2:       return tag(t0 + c, 6);
      3:       return tag(t0 + c, 4);
      4:       return tag(t0 + c + 1, 5);
      5:       return tag(t0 + c + 1, 7);
      6:       return tag(t0 + c, 3);
      7:       return tag(t0 + c + 1, 4);
      default: return tag(t0 + c + 2, 5);
    endcase
  endfunction

  // Edge counter and tap driver: after edge n the taps carry the values for edge n+1.
  initial begin
    forever begin
      @(posedge clock);
      edge_n++;
      #1;
      if (tap_const) begin
        c53 = 16'h4000; c54 = 16'h4000; c55 = 16'h4000; c35 = 16'h4000; c45 = 16'h4000;
      end else begin
        c53 = tag(edge_n + 1, 3);
        c54 = tag(edge_n + 1, 4);
        c55 = tag(edge_n + 1, 5);
        c35 = tag(edge_n + 1, 6);
        c45 = tag(edge_n + 1, 7);
      end
    end
  end

  // A write presented during a cycle commits on the following posedge.
  initial begin
    forever begin
      @(negedge clock);
      if (ena_a && wea_a) begin
        ram_a[addr_a] = dina_a;
        wr_cnt_a++;
        if (first_wr_a < 0) first_wr_a = edge_n;
        if (int'(addr_a) < min_addr_a) min_addr_a = int'(addr_a);
      end
      if (done_a) begin
        done_cnt_a++;
        last_done_a = edge_n;
        if (first_done_a < 0) first_done_a = edge_n;
      end
      if (ena_b && wea_b) begin
        ram_b[addr_b] = dina_b;
        wr_cnt_b++;
        if (first_wr_b < 0) first_wr_b = edge_n;
        if (int'(addr_b) < min_addr_b) min_addr_b = int'(addr_b);
      end
      if (done_b) begin
        done_cnt_b++;
        last_done_b = edge_n;
        if (first_done_b < 0) first_done_b = edge_n;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      ram_a[i] = 16'hDEAD;
      ram_b[i] = 16'hDEAD;
    end
    wr_cnt_a = 0; done_cnt_a = 0; first_wr_a = -1; first_done_a = -1; last_done_a = -1;
    min_addr_a = 31;
    wr_cnt_b = 0; done_cnt_b = 0; first_wr_b = -1; first_done_b = -1; last_done_b = -1;
    min_addr_b = 31;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({ena_a, wea_a, busy_a, done_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got ena/wea/busy/done=%b want 0000",
               {ena_a, wea_a, busy_a, done_a});
    end
    checks++;
    if (addr_a !== 5'd0 || dina_a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d dina=%h want 0/0000", addr_a, dina_a);
    end
    checks++;
    if ({ena_b, wea_b, busy_b, done_b} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b want 0000", {ena_b, wea_b, busy_b, done_b});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_identity();
    int t0;
    clear_models();
    tap_const = 1'b1;
    step();
    start_a = 1'b1;
    t0 = edge_n + 1;
    step();
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL ident_busy: got %b want 1", busy_a);
    end
    repeat (CA + 15) step();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ram_a[BA + k] !== 16'h4000) begin
        errors++;
        $display("FAIL ident_word%0d: got %h want 4000", k, ram_a[BA + k]);
      end
    end
    checks++;
    if (first_wr_a != t0 + CA + 2) begin
      errors++;
      $display("FAIL ident_first_write: got edge %0d want %0d", first_wr_a, t0 + CA + 2);
    end
    checks++;
    if (first_done_a != t0 + CA + 11 || done_cnt_a != 1) begin
      errors++;
      $display("FAIL ident_done: got edge %0d count %0d want %0d/1",
               first_done_a, done_cnt_a, t0 + CA + 11);
    end
    checks++;
    if (wr_cnt_a != 9 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ident_writes: got %0d busy=%b want 9/0", wr_cnt_a, busy_a);
    end
    tap_const = 1'b0;
    step();
  endtask

  task automatic test_tags();
    int t0;
    clear_models();
    step();
    start_a = 1'b1;
    t0 = edge_n + 1;
    step();
    start_a = 1'b0;
    repeat (CA + 15) step();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ram_a[BA + k] !== exp_word(t0, CA, k)) begin
        errors++;
        $display("FAIL tags_word%0d: got %h want %h", k, ram_a[BA + k], exp_word(t0, CA, k));
      end
    end
    checks++;
    if (wr_cnt_a != 9 || done_cnt_a != 1) begin
      errors++;
      $display("FAIL tags_counts: got writes=%0d dones=%0d want 9/1", wr_cnt_a, done_cnt_a);
    end
  endtask

  task automatic test_start_ignored();
    int t0;
    clear_models();
    step();
    start_a = 1'b1;
    t0 = edge_n + 1;
    step();
    start_a = 1'b0;
    step();
    start_a = 1'b1;            // sampled at t0+2 (WAIT)
    step();
    start_a = 1'b0;
    while (edge_n < t0 + CA + 4) step();
    start_a = 1'b1;            // sampled at t0+C+5 (WRITE)
    step();
    start_a = 1'b0;
    repeat (CA + 20) step();
    checks++;
    if (wr_cnt_a != 9 || done_cnt_a != 1) begin
      errors++;
      $display("FAIL ignore_counts: got writes=%0d dones=%0d want 9/1", wr_cnt_a, done_cnt_a);
    end
    checks++;
    if (first_done_a != t0 + CA + 11 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done: got edge %0d busy=%b want %0d/0",
               first_done_a, busy_a, t0 + CA + 11);
    end
    checks++;
    if (ram_a[BA + 8] !== exp_word(t0, CA, 8)) begin
      errors++;
      $display("FAIL ignore_word8: got %h want %h", ram_a[BA + 8], exp_word(t0, CA, 8));
    end
  endtask

  task automatic test_reset_mid_write();
    int t0;
    clear_models();
    step();
    start_a = 1'b1;
    t0 = edge_n + 1;
    step();
    start_a = 1'b0;
    while (edge_n < t0 + CA + 5) step();
    reset = 1'b1;              // sampled on the edge that would present word 4
    step();
    checks++;
    if ({ena_a, wea_a, busy_a, done_a} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_outputs: got ena/wea/busy/done=%b want 0000",
               {ena_a, wea_a, busy_a, done_a});
    end
    reset = 1'b0;
    repeat (5) step();
    checks++;
    if (wr_cnt_a != 4 || done_cnt_a != 0) begin
      errors++;
      $display("FAIL midrst_counts: got writes=%0d dones=%0d want 4/0", wr_cnt_a, done_cnt_a);
    end
    checks++;
    if (ram_a[BA + 3] !== exp_word(t0, CA, 3) || ram_a[BA + 4] !== 16'hDEAD) begin
      errors++;
      $display("FAIL midrst_words: got w3=%h w4=%h want %h/dead",
               ram_a[BA + 3], ram_a[BA + 4], exp_word(t0, CA, 3));
    end
    clear_models();
    start_a = 1'b1;
    t0 = edge_n + 1;
    step();
    start_a = 1'b0;
    repeat (CA + 15) step();
    checks++;
    if (wr_cnt_a != 9 || done_cnt_a != 1 || ram_a[BA + 6] !== exp_word(t0, CA, 6)) begin
      errors++;
      $display("FAIL midrst_rerun: got writes=%0d dones=%0d w6=%h want 9/1/%h",
               wr_cnt_a, done_cnt_a, ram_a[BA + 6], exp_word(t0, CA, 6));
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_models();
    step();
    start_a = 1'b1;
    t0 = edge_n + 1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (done_cnt_a >= 2) break;
    end
    start_a = 1'b0;
    repeat (CA + 20) step();
    checks++;
    if (first_done_a != t0 + CA + 11) begin
      errors++;
      $display("FAIL b2b_first_done: got edge %0d want %0d", first_done_a, t0 + CA + 11);
    end
    checks++;
    if (last_done_a != first_done_a + CA + 13) begin
      errors++;
      $display("FAIL b2b_period: got edge %0d want %0d", last_done_a, first_done_a + CA + 13);
    end
    checks++;
    if (wr_cnt_a != 18 || done_cnt_a != 2 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_counts: got writes=%0d dones=%0d busy=%b want 18/2/0",
               wr_cnt_a, done_cnt_a, busy_a);
    end
  endtask

  task automatic test_small_offset();
    int t0;
    clear_models();
    step();
    start_b = 1'b1;
    t0 = edge_n + 1;
    step();
    start_b = 1'b0;
    repeat (20) step();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ram_b[BB + k] !== exp_word(t0, CB, k)) begin
        errors++;
        $display("FAIL small_word%0d: got %h want %h", k, ram_b[BB + k], exp_word(t0, CB, k));
      end
    end
    checks++;
    if (wr_cnt_b != 9 || min_addr_b != BB || ram_b[0] !== 16'hDEAD) begin
      errors++;
      $display("FAIL small_nowrap: got writes=%0d min_addr=%0d ram0=%h want 9/%0d/dead",
               wr_cnt_b, min_addr_b, ram_b[0], BB);
    end
    checks++;
    if (first_done_b != t0 + CB + 11 || done_cnt_b != 1) begin
      errors++;
      $display("FAIL small_done: got edge %0d count %0d want %0d/1",
               first_done_b, done_cnt_b, t0 + CB + 11);
    end
  endtask

  initial begin
    clear_models();
    test_reset();
    test_identity();
    test_tags();
    test_start_ignored();
    test_reset_mid_write();
    test_back_to_back();
    test_small_offset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
